wb_burst_arbiter: RTL
=====================

# wb_burst_arbiter

Three-master Wishbone burst arbiter that shares the single SoC data port (the `cpu2dmux_*` bus) between the I-cache refill master, the D-cache refill/writeback master and the uncached "others" master. It grants one master at a time using round-robin priority. The grant is held for a whole burst, counted by the master's burst-length field, and acks and read data are steered back to the granted master only. It replaces the separate direct I-cache path and the two-master arbiter in the top level, so all core memory traffic leaves through one port.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; `DW/8` select bits.
- `BLW`, 10, burst-length field width.
- `TIMEOUT_CYC`, 255, watchdog limit in cycles. Used only with `WB_ARB_TIMEOUT_EN`.

Ports. Master group x is one of {0 = icache, 1 = dcache, 2 = others}.
- `clk`  in  1  single clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `mx_cyc_i`  in  1  bus request / cycle valid.
- `mx_stb_i`  in  1  strobe.
- `mx_we_i`  in  1  write enable.
- `mx_adr_i`  in  AW  address.
- `mx_dat_i`  in  DW  write data.
- `mx_sel_i`  in  DW/8  byte select.
- `mx_bl_i`  in  BLW  burst beats. 0 is treated as 1.
- `mx_dat_o`  out  DW  read data. Driven to the granted master only, else 0.
- `mx_ack_o`  out  1  beat acknowledge. Granted master only.
- `s_cyc_o`, `s_stb_o`, `s_we_o`, `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_bl_o`  out  as above  muxed slave request.
- `s_bry_o`  out  1  burst ready: the granted master can accept or supply a beat.
- `s_ack_i`  in  1  slave beat acknowledge.
- `s_dat_i`  in  DW  slave read data.
- `grant_o`  out  3  one-hot current grant, for debug or LA.
- `timeout_o`  out  1  one-cycle pulse on watchdog abort.

## Operation
- FSM states are IDLE and BUSY.
- Reset values:
  - state = IDLE, grant = 000, round-robin pointer = m0.
  - Beat counter = 0, watchdog = 0.
  - All `s_*` outputs, `mx_ack_o`, `mx_dat_o` and `timeout_o` are 0.
- IDLE:
  - If any `mx_cyc_i` is high, pick a master by round-robin. Search order starts at the master after the last granted one; the initial order is m0, m1, m2.
  - Register the grant, load the beat counter with `mx_bl_i` (0 becomes 1), then go to BUSY.
- BUSY:
  - The `s_*` request outputs are combinational muxes of the granted master's inputs, gated by grant.
  - `s_bry_o` = `cyc & stb` of the granted master.
  - `s_ack_i` and `s_dat_i` route combinationally to the granted master only. Non-granted masters see ack 0 and data 0.
  - Each `s_ack_i` decrements the beat counter.
- Release from BUSY to IDLE occurs when either condition holds:
  - `s_ack_i` arrives while the counter is 1 (the last beat); or
  - the granted `mx_cyc_i` drops (master abort). Any in-flight ack in that cycle is still forwarded.
- On release, grant clears, the pointer advances past the released master, and there is one idle cycle before the next grant.
- The `bl` value is sampled only at grant. Changes during a burst are ignored.
- Requests from non-granted masters are held pending (not acked). Wishbone requires them to keep `cyc` high.

## Timing
- Grant latency: `mx_cyc_i` rises in cycle N, and `s_cyc_o` plus `grant_o` are valid in N+1.
- Beat path: `s_ack_i` to `mx_ack_o` is zero-cycle (combinational).
- Turnaround: after a release in cycle M, the earliest next `s_cyc_o` is M+2.
- Simultaneous requests in IDLE: round-robin decides. A master that was just served has lowest priority.
- If the granted `cyc` drops in the same cycle as the last-beat ack, the arbiter performs a single release with no double count.
- Asserting `rstn` mid-burst returns the arbiter to reset values immediately. Slave and master outputs drop asynchronously.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - In BUSY, the watchdog counts cycles since grant or since the last `s_ack_i`.
  - When it reaches `TIMEOUT_CYC`, the arbiter:
    - drops `s_cyc_o` and `s_stb_o`;
    - drives one `mx_ack_o` to the granted master with `mx_dat_o` = 32'hDEADBEEF;
    - pulses `timeout_o` for one cycle;
    - returns to IDLE.
- `WB_ARB_TIMEOUT_EN` undefined: there is no watchdog, `timeout_o` is tied to 0, and a hung slave holds the grant indefinitely.

## Structure
- Package `wb_arb_pkg` holds:
  - the state enum (IDLE, BUSY);
  - `NUM_MASTERS` = 3;
  - the master index constants ICACHE / DCACHE / OTHERS;
  - the `TIMEOUT_DATA` = 32'hDEADBEEF constant.
- Sub-module `rr_pick3`: combinational round-robin picker. Inputs are the 3-bit request vector and the 3-bit one-hot last-grant pointer; output is the one-hot pick. It is instantiated once.

## Test plan
- Single request: m2 issues a 1-beat read with `bl`=0, and the slave acks in cycle 3 with 0x1234_5678 → `s_cyc_o` rises at N+1, m2 gets ack and 0x1234_5678, `grant_o` returns to 000 at the next cycle.
- Burst hold: m0 issues an 8-beat read while m1 requests at beat 2 → m1 sees no ack until m0's 8th ack. m1 is granted 2 cycles after that ack, and `s_adr_o` switches to m1's address.
- Round-robin: all three masters request continuously with 1-beat transfers → grant order is m0, m1, m2, m0, with exactly one idle cycle between grants.
- Master abort: m1 issues a 4-beat write and drops `cyc` after 2 acks → release occurs, the counter is discarded, and the next requester is granted normally.
- Reset mid-burst: `rstn` is driven low during beat 3 of m0 → all outputs are 0 immediately. After release of reset, the first grant goes to m0 under the pointer reset value.
- Watchdog (with `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYC`=16): the slave never acks → at cycle 16 after grant, m1 receives one ack with 0xDEADBEEF, `timeout_o` pulses for 1 cycle, and the arbiter returns to IDLE.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the three-master Wishbone burst arbiter.
package wb_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int NUM_MASTERS = 3;

    localparam logic [1:0] ICACHE = 2'd0;
    localparam logic [1:0] DCACHE = 2'd1;
    localparam logic [1:0] OTHERS = 2'd2;

    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    function automatic logic [NUM_MASTERS-1:0] rotl3(input logic [NUM_MASTERS-1:0] v);
        return {v[NUM_MASTERS-2:0], v[NUM_MASTERS-1]};
    endfunction

    function automatic logic [NUM_MASTERS-1:0] rotr3(input logic [NUM_MASTERS-1:0] v);
        return {v[0], v[NUM_MASTERS-1:1]};
    endfunction

endpackage

// File: rtl/rr_pick3.sv
// Combinational round-robin picker for three requesters; the search starts
// at the requester after the one-hot last grant.
module rr_pick3
    import wb_arb_pkg::*;
(
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [NUM_MASTERS-1:0] last_grant,
    output logic [NUM_MASTERS-1:0] pick
);

    always_comb begin
        pick = '0;
        case (last_grant)
            3'b001: begin
                if      (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
            end
            3'b010: begin
                if      (req[2]) pick = 3'b100;
                else if (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
            end
            default: begin
                if      (req[0]) pick = 3'b001;
                else if (req[1]) pick = 3'b010;
                else if (req[2]) pick = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/wb_burst_arbiter.sv
// Three-master Wishbone burst arbiter: round-robin grant held for a whole burst.
// Define WB_ARB_TIMEOUT_EN to add the watchdog abort (TIMEOUT_CYC cycles without an ack).
module wb_burst_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int BLW         = 10,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [BLW-1:0]  m0_bl_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [BLW-1:0]  m1_bl_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,

    input  logic            m2_cyc_i,
    input  logic            m2_stb_i,
    input  logic            m2_we_i,
    input  logic [AW-1:0]   m2_adr_i,
    input  logic [DW-1:0]   m2_dat_i,
    input  logic [DW/8-1:0] m2_sel_i,
    input  logic [BLW-1:0]  m2_bl_i,
    output logic [DW-1:0]   m2_dat_o,
    output logic            m2_ack_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [BLW-1:0]  s_bl_o,
    output logic            s_bry_o,
    input  logic            s_ack_i,
    input  logic [DW-1:0]   s_dat_i,

    output logic [2:0]      grant_o,
    output logic            timeout_o
);

    state_t                 state;
    logic [NUM_MASTERS-1:0] grant;
    logic [NUM_MASTERS-1:0] rr_ptr;
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] pick;
    logic [BLW-1:0]         beats;
    logic [BLW-1:0]         bl_pick;
    logic [BLW-1:0]         bl_load;

    logic                   cyc_g;
    logic                   stb_g;
    logic                   we_g;
    logic [AW-1:0]          adr_g;
    logic [DW-1:0]          dat_g;
    logic [DW/8-1:0]        sel_g;
    logic [BLW-1:0]         bl_g;

    logic                   wd_hit;
    logic                   release_now;
    logic                   ack_any;
    logic [DW-1:0]          rdata;

    assign req = {m2_cyc_i, m1_cyc_i, m0_cyc_i};

    // rr_ptr holds the highest-priority master; the picker wants the previous one.
    rr_pick3 u_pick (
        .req        (req),
        .last_grant (rotr3(rr_ptr)),
        .pick       (pick)
    );

    always_comb begin
        cyc_g = 1'b0;
        stb_g = 1'b0;
        we_g  = 1'b0;
        adr_g = '0;
        dat_g = '0;
        sel_g = '0;
        bl_g  = '0;
        case (grant)
            3'b001: begin
                cyc_g = m0_cyc_i; stb_g = m0_stb_i; we_g = m0_we_i;
                adr_g = m0_adr_i; dat_g = m0_dat_i; sel_g = m0_sel_i; bl_g = m0_bl_i;
            end
            3'b010: begin
                cyc_g = m1_cyc_i; stb_g = m1_stb_i; we_g = m1_we_i;
                adr_g = m1_adr_i; dat_g = m1_dat_i; sel_g = m1_sel_i; bl_g = m1_bl_i;
            end
            3'b100: begin
                cyc_g = m2_cyc_i; stb_g = m2_stb_i; we_g = m2_we_i;
                adr_g = m2_adr_i; dat_g = m2_dat_i; sel_g = m2_sel_i; bl_g = m2_bl_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        bl_pick = '0;
        case (pick)
            3'b001:  bl_pick = m0_bl_i;
            3'b010:  bl_pick = m1_bl_i;
            3'b100:  bl_pick = m2_bl_i;
            default: ;
        endcase
    end

    assign bl_load = (bl_pick == '0) ? BLW'(1) : bl_pick;

    assign s_cyc_o = cyc_g & ~wd_hit;
    assign s_stb_o = stb_g & ~wd_hit;
    assign s_we_o  = we_g;
    assign s_adr_o = adr_g;
    assign s_dat_o = dat_g;
    assign s_sel_o = sel_g;
    assign s_bl_o  = bl_g;
    assign s_bry_o = cyc_g & stb_g;
    assign grant_o = grant;

    assign ack_any = s_ack_i | wd_hit;
    assign rdata   = wd_hit ? DW'(TIMEOUT_DATA) : s_dat_i;

    assign m0_ack_o = grant[ICACHE] & ack_any;
    assign m1_ack_o = grant[DCACHE] & ack_any;
    assign m2_ack_o = grant[OTHERS] & ack_any;
    assign m0_dat_o = grant[ICACHE] ? rdata : '0;
    assign m1_dat_o = grant[DCACHE] ? rdata : '0;
    assign m2_dat_o = grant[OTHERS] ? rdata : '0;

    // A dropped cyc and a last-beat ack in the same cycle collapse into one release.
    assign release_now = (state == BUSY) &&
                         ((s_ack_i && (beats == BLW'(1))) || !cyc_g || wd_hit);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            grant  <= '0;
            rr_ptr <= 3'b001;
            beats  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        grant <= pick;
                        beats <= bl_load;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (release_now) begin
                        grant  <= '0;
                        rr_ptr <= rotl3(grant);
                        beats  <= '0;
                        state  <= IDLE;
                    end else if (s_ack_i) begin
                        beats <= beats - BLW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYC + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_hit    = (state == BUSY) && (wd_cnt == WDW'(TIMEOUT_CYC));
    assign timeout_o = wd_hit;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wd_cnt <= '0;
        end else if ((state != BUSY) || release_now || s_ack_i) begin
            wd_cnt <= '0;
        end else begin
            wd_cnt <= wd_cnt + WDW'(1);
        end
    end
`else
    logic unused_timeout_cfg;

    assign wd_hit             = 1'b0;
    assign timeout_o          = 1'b0;
    assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

endmodule
